// File: rtl/td4_datapath.sv
// ---------------------------------------------------------------------------
// td4_datapath
//   Register/execute stage of the TD4 CPU. Sits directly after the
//   instruction decoder and holds A, B, OUT, PC and the carry flag. Each
//   enabled cycle retires one instruction: the selected operand is added to
//   the immediate, and the result is written to every register whose
//   active-low load bit is clear. PC steps by one when it is not loaded.
//
// Ports
//   clk      in   system clock, all state on rising edge
//   rst      in   synchronous reset, active-high, priority over en
//   en       in   step enable; state holds when low
//   select   in   operand select: 00=A, 01=B, 10=in_port, 11=zero
//   load     in   active-low load enables: [0]=A [1]=B [2]=OUT [3]=PC
//   imm      in   instruction immediate
//   in_port  in   external input port
//   pc       out  program counter (ROM address)
//   out_port out  OUT register
//   carry    out  carry flag, fed back to the decoder
//   reg_a    out  A register
//   reg_b    out  B register
//   halted   out  (TD4_HALT_DETECT_EN only) sticky jump-to-self detect
//
// Optional feature macro: TD4_HALT_DETECT_EN
//   When defined, a jump whose target equals the current PC sets halted,
//   and all later state updates are frozen until rst.
// ---------------------------------------------------------------------------
module td4_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       select,
  input  logic [3:0]       load,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] out_port,
  output logic             carry,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b
`ifdef TD4_HALT_DETECT_EN
  ,
  output logic             halted
`endif
);

  // Unsigned add with the carry-out kept as the extra top bit.
  function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             nop;
  logic             step;

  always_comb begin
    op = '0;
    case (select)
      2'b00:   op = reg_a;
      2'b01:   op = reg_b;
      2'b10:   op = in_port;
      default: op = '0;
    endcase
  end

  assign {cout, sum} = add_op(op, imm);

  // All load bits high is the not-taken JNC: select may be X, so the
  // carry is forced to 0 rather than taken from the adder.
  assign nop = &load;

`ifdef TD4_HALT_DETECT_EN
  assign step = en & ~halted;
`else
  assign step = en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      pc       <= '0;
      carry    <= 1'b0;
`ifdef TD4_HALT_DETECT_EN
      halted   <= 1'b0;
`endif
    end else if (step) begin
      if (!load[0]) reg_a    <= sum;
      if (!load[1]) reg_b    <= sum;
      if (!load[2]) out_port <= sum;
      pc    <= load[3] ? pc + 1'b1 : sum;
      carry <= nop ? 1'b0 : cout;
`ifdef TD4_HALT_DETECT_EN
      // The halting cycle itself still commits its writes above.
      if (!load[3] && (sum == pc)) halted <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_td4_datapath.sv
// ---------------------------------------------------------------------------
// tb_td4_datapath
//   Self-checking bench for td4_datapath. A behavioural model computes the
//   expected register state for each driven cycle, pushes it to a queue, and
//   the entry is popped and compared once the DUT has taken the clock edge.
// ---------------------------------------------------------------------------
module tb_td4_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] select;
  logic [3:0] load;
  logic [3:0] imm;
  logic [3:0] in_port;
  logic [3:0] pc;
  logic [3:0] out_port;
  logic       carry;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
`ifdef TD4_HALT_DETECT_EN
  logic       halted;
`endif

  td4_datapath #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .select   (select),
    .load     (load),
    .imm      (imm),
    .in_port  (in_port),
    .pc       (pc),
    .out_port (out_port),
    .carry    (carry),
    .reg_a    (reg_a),
    .reg_b    (reg_b)
`ifdef TD4_HALT_DETECT_EN
    ,
    .halted   (halted)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic [3:0] p;
    logic       c;
    logic       h;
  } exp_t;

  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_a = 4'h0, m_b = 4'h0, m_o = 4'h0, m_p = 4'h0;
  logic       m_c = 1'b0, m_h = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one cycle and queue the expected state.
  task automatic model_step(input logic r, input logic e, input logic [1:0] s,
                            input logic [3:0] l, input logic [3:0] im,
                            input logic [3:0] ip);
    logic [3:0] op;
    logic [4:0] t;
    exp_t x;
    if (r) begin
      m_a = 0; m_b = 0; m_o = 0; m_p = 0; m_c = 0; m_h = 0;
    end else if (e && !m_h) begin
      op = (s == 2'b00) ? m_a : (s == 2'b01) ? m_b : (s == 2'b10) ? ip : 4'h0;
      t  = {1'b0, op} + {1'b0, im};
      if (l == 4'b1111) begin
        m_c = 1'b0;
        m_p = m_p + 4'h1;
      end else begin
`ifdef TD4_HALT_DETECT_EN
        if (!l[3] && t[3:0] == m_p) m_h = 1'b1;
`endif
        if (!l[0]) m_a = t[3:0];
        if (!l[1]) m_b = t[3:0];
        if (!l[2]) m_o = t[3:0];
        m_p = l[3] ? m_p + 4'h1 : t[3:0];
        m_c = t[4];
      end
    end
    x = '{a: m_a, b: m_b, o: m_o, p: m_p, c: m_c, h: m_h};
    exp_q.push_back(x);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [3:0] l, input logic [3:0] im,
                      input logic [3:0] ip);
    exp_t x;
    model_step(r, e, s, l, im, ip);
    rst = r; en = e; select = s; load = l; imm = im; in_port = ip;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check("reg_a", reg_a, x.a);
      check("reg_b", reg_b, x.b);
      check("out_port", out_port, x.o);
      check("pc", pc, x.p);
      check("carry", carry, x.c);
`ifdef TD4_HALT_DETECT_EN
      check("halted", halted, x.h);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; select = 2'b00; load = 4'hF; imm = 4'h0; in_port = 4'h0;
    @(negedge clk);

    // Reset state
    step(1, 1, 2'b00, 4'b1111, 4'h0, 4'h0);

    // ADD A,Im with overflow and without
    step(0, 1, 2'b11, 4'b1110, 4'hE, 4'h0);   // MOV A,E
    step(0, 1, 2'b00, 4'b1110, 4'h3, 4'h0);   // A=1, carry=1
    step(0, 1, 2'bxx, 4'b1111, 4'h5, 4'h0);   // JNC not taken
    step(0, 1, 2'b00, 4'b1110, 4'h1, 4'h0);   // A=2, carry=0
    step(0, 1, 2'b11, 4'b0111, 4'h9, 4'h0);   // JNC taken -> PC=9

    // IN B / OUT B / multiple loads
    step(0, 1, 2'b10, 4'b1101, 4'h0, 4'h6);
    step(0, 1, 2'b01, 4'b1011, 4'h0, 4'h3);
    step(0, 1, 2'b11, 4'b1100, 4'h5, 4'h0);

    // PC wrap
    step(0, 1, 2'b11, 4'b0111, 4'hF, 4'h0);
    step(0, 1, 2'b00, 4'b1111, 4'h0, 4'h0);

    // en=0 holds state
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

    // Reset with en=1 and en=0 after activity
    step(0, 1, 2'b10, 4'b0000, 4'h7, 4'hA);
    step(1, 1, 2'b10, 4'b0000, 4'h7, 4'hA);
    step(0, 1, 2'b11, 4'b1000, 4'hB, 4'h0);
    step(1, 0, 2'b11, 4'b1000, 4'hB, 4'h0);

    // Random instruction mix
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));

`ifdef TD4_HALT_DETECT_EN
    // Jump-to-self halts and freezes state until reset
    step(1, 1, 2'b00, 4'b1111, 4'h0, 4'h0);
    step(0, 1, 2'b11, 4'b0111, 4'h4, 4'h0);   // PC=4
    step(0, 1, 2'b11, 4'b0110, 4'h4, 4'h0);   // jump-to-self, A<=4 commits
    step(0, 1, 2'b00, 4'b1110, 4'h3, 4'h0);   // suppressed
    step(0, 1, 2'b11, 4'b1101, 4'h9, 4'h0);   // suppressed
    step(1, 1, 2'b00, 4'b1111, 4'h0, 4'h0);   // clears halted
    step(0, 1, 2'b00, 4'b1110, 4'h3, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1);
  end

endmodule
